// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/DE timing, all outputs registered together.
// Define VGA_PATTERN_EN to build the internal test-pattern source in place of pix_rgb.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CW        = 4,
    parameter int   CNT_W     = 10,
    parameter int   CHK_SHIFT = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   solid_rgb,
`ifndef VGA_PATTERN_EN
    input  logic [3*CW-1:0]   pix_rgb,
`endif
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [CNT_W-1:0]  x,
    output logic [CNT_W-1:0]  y,
    output logic [3*CW-1:0]   rgb,
    output logic              frame_start,
    output logic              line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_de;
    logic             w_hs;
    logic             w_vs;
    logic             w_fs;
    logic             w_ls;
    logic [3*CW-1:0]  w_rgb;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_de = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_hs = ((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        w_vs = ((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END)) ? VS_POL : ~VS_POL;
        w_fs = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_ls = (r_h_cnt == '0) && (r_v_cnt < V_ACT);
    end

`ifdef VGA_PATTERN_EN
    localparam int               BW      = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BW - 1);

    logic [1:0]       r_mode_q;
    logic [CNT_W-1:0] r_bar_px;
    logic [2:0]       r_bar_idx;
    logic [2:0]       w_bar;
    logic             w_chk;
    logic [3*CW-1:0]  w_pat;

    // Bar index stays at 7 once reached, so the last bar absorbs the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q  <= 2'd0;
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
        end else begin
            if (w_h_last && w_v_last) begin
                r_mode_q <= mode;
            end
            if (w_h_last) begin
                r_bar_px  <= '0;
                r_bar_idx <= 3'd0;
            end else if (r_bar_px == BW_LAST && r_bar_idx != 3'd7) begin
                r_bar_px  <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_px <= r_bar_px + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_bar = 3'b000;
        case (r_bar_idx)
            3'd0:    w_bar = 3'b111;
            3'd1:    w_bar = 3'b110;
            3'd2:    w_bar = 3'b011;
            3'd3:    w_bar = 3'b010;
            3'd4:    w_bar = 3'b101;
            3'd5:    w_bar = 3'b100;
            3'd6:    w_bar = 3'b001;
            default: w_bar = 3'b000;
        endcase
    end

    assign w_chk = r_h_cnt[CHK_SHIFT] ^ r_v_cnt[CHK_SHIFT];

    always_comb begin
        w_pat = '0;
        case (r_mode_q)
            2'd0:    w_pat = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
            2'd1:    w_pat = {3*CW{w_chk}};
            2'd2:    w_pat = {r_h_cnt[CNT_W-1 -: CW], r_v_cnt[CNT_W-1 -: CW], CW'(0)};
            default: w_pat = solid_rgb;
        endcase
    end

    assign w_rgb = w_de ? w_pat : '0;
`else
    logic w_unused;

    assign w_unused = ^{mode, solid_rgb};
    assign w_rgb    = w_de ? pix_rgb : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            rgb         <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= w_hs;
            vsync       <= w_vs;
            de          <= w_de;
            x           <= r_h_cnt;
            y           <= r_v_cnt;
            rgb         <= w_rgb;
            frame_start <= w_fs;
            line_start  <= w_ls;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default-timing and a small, positive-polarity
// instance of vga_timing_gen sharing clock and reset.
module tb_vga_timing_gen;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [11:0] solid = 12'h000;
    logic [11:0] pix   = 12'hABC;

    logic        d_hs, d_vs, d_de, d_fs, d_ls;
    logic [9:0]  d_x, d_y;
    logic [11:0] d_rgb;
    logic        s_hs, s_vs, s_de, s_fs, s_ls;
    logic [4:0]  s_x, s_y;
    logic [11:0] s_rgb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_d (
        .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid),
`ifndef VGA_PATTERN_EN
        .pix_rgb(pix),
`endif
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .rgb(d_rgb), .frame_start(d_fs), .line_start(d_ls)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .CNT_W(5), .CHK_SHIFT(2)
    ) u_dut_s (
        .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid),
`ifndef VGA_PATTERN_EN
        .pix_rgb(pix),
`endif
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .rgb(s_rgb), .frame_start(s_fs), .line_start(s_ls)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pixf(input int c);
        return 12'(c * 37 + 2748);
    endfunction

    int          d_pts[12] = '{0, 79, 80, 159, 160, 560, 639, 640, 700, 800, 879, 880};
    logic [11:0] d_bar[12] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0, 12'h0FF, 12'h000,
                               12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFF0};
    int          s_pts[17] = '{0, 2, 4, 15, 16, 24, 604, 720, 736, 802, 960, 964,
                               1056, 1060, 1208, 1335, 1440};
    logic [11:0] s_pat[17] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h000, 12'h000, 12'hFFF,
                               12'h0FF, 12'h5A3, 12'h000, 12'h5A3, 12'h000, 12'hFFF,
                               12'hFFF, 12'h000, 12'h400, 12'h720, 12'hFFF};

    function automatic logic [11:0] exp_d(input int k, input int c);
`ifdef VGA_PATTERN_EN
        if (c < 0) return 12'h000;
        return d_bar[k];
`else
        if (k < 0) return 12'h000;
        return ((c % 800) < 640 && (c / 800) < 480) ? pixf(c) : 12'h000;
`endif
    endfunction

    function automatic logic [11:0] exp_s(input int k, input int c);
`ifdef VGA_PATTERN_EN
        if (c < 0) return 12'h000;
        return s_pat[k];
`else
        if (k < 0) return 12'h000;
        return ((c % 24) < 16 && ((c % 240) / 24) < 6) ? pixf(c) : 12'h000;
`endif
    endfunction

    initial begin
        int d_hs_first = -1, d_hs_low = 0, d_de0 = 0, d_de1 = 0;
        int d_ls2 = -1, d_vs_low = 0, gate_err = 0;
        int s_fs2 = -1, s_fs_n = 0, s_hs_first = -1, s_hs_n = 0;
        int s_vs_first = -1, s_vs_n = 0, s_de_n = 0, s_ls_n = 0;
        logic [11:0] rst_exp;

        repeat (5) @(posedge clk);
        #1;
        check("rst_d_ctl", 32'({d_hs, d_vs, d_de, d_fs, d_ls}), 32'h18);
        check("rst_d_xy", 32'({d_x, d_y}), 32'h0);
        check("rst_d_rgb", 32'(d_rgb), 32'h0);
        check("rst_s_ctl", 32'({s_hs, s_vs, s_de, s_fs, s_ls}), 32'h00);
        check("rst_s_xyrgb", 32'({s_x, s_y, s_rgb}), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 1700; c++) begin
            pix = pixf(c);
            if (c == 528) begin
                mode  = 2'd3;
                solid = 12'h5A3;
            end
            if (c == 800)  mode = 2'd1;
            if (c == 1000) mode = 2'd2;
            if (c == 1300) mode = 2'd0;
            if (c == 1500) mode = 2'd3;
            @(posedge clk);
            #1;
            if (c == 0) begin
                check("d_first_ctl", 32'({d_de, d_fs, d_ls}), 32'h7);
                check("d_first_xy", 32'({d_x, d_y}), 32'h0);
                check("s_first_ctl", 32'({s_de, s_fs, s_ls}), 32'h7);
                check("s_first_xy", 32'({s_x, s_y}), 32'h0);
            end
            if (c == 1) begin
                check("d_c1_strobes", 32'({d_fs, d_ls}), 32'h0);
                check("d_c1_x", 32'(d_x), 32'h1);
            end
            if (c == 800) begin
                check("d_line1_ctl", 32'({d_fs, d_ls}), 32'h1);
                check("d_line1_xy", 32'({d_x, d_y}), 32'h1);
            end
            if (c == 720)  check("s_fs_frame3", 32'(s_fs), 32'h1);
            if (c == 1335) check("s_xy_1335", 32'({s_x, s_y}), 32'h1E5);
            foreach (d_pts[k])
                if (c == d_pts[k])
                    check($sformatf("d_rgb@%0d", c), 32'(d_rgb), 32'(exp_d(k, c)));
            foreach (s_pts[k])
                if (c == s_pts[k])
                    check($sformatf("s_rgb@%0d", c), 32'(s_rgb), 32'(exp_s(k, c)));

            if (!d_de && d_rgb != 12'h0) gate_err++;
            if (!s_de && s_rgb != 12'h0) gate_err++;
            if (c < 800) begin
                if (!d_hs) begin
                    d_hs_low++;
                    if (d_hs_first < 0) d_hs_first = c;
                end
                if (d_de) d_de0++;
            end
            if (c >= 800 && c < 1600 && d_de) d_de1++;
            if (c > 0 && d_ls && d_ls2 < 0) d_ls2 = c;
            if (!d_vs) d_vs_low++;
            if (c > 0 && s_fs && s_fs2 < 0) s_fs2 = c;
            if (s_fs) s_fs_n++;
            if (c < 24 && s_hs) begin
                s_hs_n++;
                if (s_hs_first < 0) s_hs_first = c;
            end
            if (c < 240) begin
                if (s_vs) begin
                    s_vs_n++;
                    if (s_vs_first < 0) s_vs_first = c;
                end
                if (s_de) s_de_n++;
                if (s_ls) s_ls_n++;
            end
        end

        check("d_hs_start", 32'(d_hs_first), 32'd656);
        check("d_hs_width", 32'(d_hs_low), 32'd96);
        check("d_de_line0", 32'(d_de0), 32'd640);
        check("d_de_line1", 32'(d_de1), 32'd640);
        check("d_line_period", 32'(d_ls2), 32'd800);
        check("d_vs_early", 32'(d_vs_low), 32'd0);
        check("rgb_gating", 32'(gate_err), 32'd0);
        check("s_frame_period", 32'(s_fs2), 32'd240);
        check("s_frame_count", 32'(s_fs_n), 32'd8);
        check("s_hs_start", 32'(s_hs_first), 32'd18);
        check("s_hs_width", 32'(s_hs_n), 32'd3);
        check("s_vs_start", 32'(s_vs_first), 32'd168);
        check("s_vs_width", 32'(s_vs_n), 32'd48);
        check("s_de_frame", 32'(s_de_n), 32'd96);
        check("s_ls_frame", 32'(s_ls_n), 32'd6);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_d_ctl", 32'({d_hs, d_vs, d_de, d_fs, d_ls}), 32'h18);
        check("arst_d_xy", 32'({d_x, d_y}), 32'h0);
        check("arst_d_rgb", 32'(d_rgb), 32'h0);
        check("arst_s_ctl", 32'({s_hs, s_vs, s_de, s_fs, s_ls}), 32'h00);
        check("arst_s_xyrgb", 32'({s_x, s_y, s_rgb}), 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        pix   = 12'h3C7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef VGA_PATTERN_EN
        rst_exp = 12'hFFF;
`else
        rst_exp = 12'h3C7;
`endif
        check("rel_d_ctl", 32'({d_de, d_fs, d_ls}), 32'h7);
        check("rel_d_xy", 32'({d_x, d_y}), 32'h0);
        check("rel_d_rgb", 32'(d_rgb), 32'(rst_exp));
        check("rel_s_ctl", 32'({s_de, s_fs, s_ls}), 32'h7);
        check("rel_s_xy", 32'({s_x, s_y}), 32'h0);
        check("rel_s_rgb", 32'(s_rgb), 32'(rst_exp));
        @(posedge clk);
        #1;
        check("rel_d_x1", 32'({d_x, d_fs, d_ls}), 32'h4);
        check("rel_s_x1", 32'({s_x, s_fs, s_ls}), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
